// File: rtl/fp16_result_fifo.sv
// fp16_result_fifo: classifies and packs fp16 adder results into a first-word-fall-through FIFO
// with optional NaN canonicalisation, subnormal flush and a saturating NaN event counter.
module fp16_result_fifo #(
    parameter int DEPTH     = 4,
    parameter bit CANON_NAN = 1'b1,
    parameter bit FTZ       = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [4:0]               in_exp,
    input  logic [9:0]               in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [2:0]               out_class,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               nan_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] C_ZERO = 3'd0, C_SUB = 3'd1, C_NORM = 3'd2, C_INF = 3'd3, C_NAN = 3'd4;
    logic [AW-1:0] wptr, rptr;
    logic [15:0]   mem_d [DEPTH];
    logic [2:0]    mem_c [DEPTH];
    logic [15:0]   hold_d;
    logic [2:0]    hold_c;
    logic          push, pop, exp_max, exp_zero, mant_zero, is_nan, is_inf, is_sub;
    logic [15:0]   pk_d;
    logic [2:0]    pk_c;
    assign exp_max   = &in_exp;
    assign exp_zero  = ~|in_exp;
    assign mant_zero = ~|in_mant;
    assign is_nan    = exp_max & ~mant_zero;
    assign is_inf    = exp_max & mant_zero;
    assign is_sub    = exp_zero & ~mant_zero;
    assign pk_c = is_nan ? C_NAN : is_inf ? C_INF : exp_zero ? ((is_sub && !FTZ) ? C_SUB : C_ZERO) : C_NORM;
    assign pk_d = (is_nan && CANON_NAN) ? 16'h7E00 :
                  (is_sub && FTZ) ? {in_sign, 15'b0} : {in_sign, in_exp, in_mant};
    assign in_ready  = count < (AW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // When empty the outputs show the last popped word rather than stale storage.
    assign out_data  = out_valid ? mem_d[rptr] : hold_d;
    assign out_class = out_valid ? mem_c[rptr] : hold_c;
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wptr] <= pk_d;
            mem_c[wptr] <= pk_c;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            hold_d  <= 16'h0000;
            hold_c  <= C_ZERO;
            nan_cnt <= 8'h00;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr   <= rptr + 1'b1;
                hold_d <= mem_d[rptr];
                hold_c <= mem_c[rptr];
            end
            if (push && !pop) count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (push && is_nan && nan_cnt != 8'hFF) nan_cnt <= nan_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_fp16_result_fifo.sv
// tb_fp16_result_fifo: directed table-driven bench with hand sequences for fill, streaming and reset.
module tb_fp16_result_fifo;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_sign, out_ready;
    logic [4:0]  in_exp;
    logic [9:0]  in_mant;
    logic        in_ready, out_valid, f_in_ready, f_out_valid;
    logic [15:0] out_data, f_out_data;
    logic [2:0]  out_class, f_out_class, count, f_count;
    logic [7:0]  nan_cnt, f_nan_cnt;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic s; logic [4:0] e; logic [9:0] m;
        logic [15:0] d; logic [2:0] c; logic [15:0] fd; logic [2:0] fc;
    } vec_t;
    vec_t vec [8];

    fp16_result_fifo #(.DEPTH(4), .CANON_NAN(1'b1), .FTZ(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_class(out_class), .count(count), .nan_cnt(nan_cnt));

    fp16_result_fifo #(.DEPTH(4), .CANON_NAN(1'b1), .FTZ(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(f_in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data),
        .out_class(f_out_class), .count(f_count), .nan_cnt(f_nan_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [4:0] e, input logic [9:0] m);
        in_sign = s;
        in_exp  = e;
        in_mant = m;
    endtask

    function automatic logic [15:0] fill_word(input int i);
        return {1'b0, 5'(i + 1), 10'(i)};
    endfunction

    function automatic logic [15:0] stream_word(input int k);
        return {1'b1, 5'd3, 10'(k * 7)};
    endfunction

    initial begin
        vec[0] = '{1'b0, 5'b10010, 10'b0010000000, 16'h4880, 3'd2, 16'h4880, 3'd2};
        vec[1] = '{1'b1, 5'd31,    10'd1,          16'h7E00, 3'd4, 16'h7E00, 3'd4};
        vec[2] = '{1'b1, 5'd31,    10'd0,          16'hFC00, 3'd3, 16'hFC00, 3'd3};
        vec[3] = '{1'b1, 5'd0,     10'b0000000101, 16'h8005, 3'd1, 16'h8000, 3'd0};
        vec[4] = '{1'b1, 5'd0,     10'd0,          16'h8000, 3'd0, 16'h8000, 3'd0};
        vec[5] = '{1'b0, 5'd30,    10'h3FF,        16'h7BFF, 3'd2, 16'h7BFF, 3'd2};
        vec[6] = '{1'b0, 5'd31,    10'h200,        16'h7E00, 3'd4, 16'h7E00, 3'd4};
        vec[7] = '{1'b0, 5'd1,     10'd0,          16'h0400, 3'd2, 16'h0400, 3'd2};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(1'b0, 5'd0, 10'd0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_class", 32'(out_class), 32'd0);
        chk("rst_nan_cnt", 32'(nan_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // single push then pop; empty outputs hold the last popped word
        in_valid = 1'b1;
        drive(1'b0, 5'b10010, 10'b0010000000);
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h4880);
        chk("single_class", 32'(out_class), 32'd2);
        chk("single_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_valid", 32'(out_valid), 32'd0);
        chk("single_pop_count", 32'(count), 32'd0);
        chk("single_hold_data", 32'(out_data), 32'h4880);

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            drive(vec[i].s, vec[i].e, vec[i].m);
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vec[i].d));
            chk($sformatf("vec%0d_class", i), 32'(out_class), 32'(vec[i].c));
            chk($sformatf("vec%0d_ftz_data", i), 32'(f_out_data), 32'(vec[i].fd));
            chk($sformatf("vec%0d_ftz_class", i), 32'(f_out_class), 32'(vec[i].fc));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'd0);
        end
        chk("table_nan_cnt", 32'(nan_cnt), 32'd2);

        // fill to full, refuse a fifth word, drain in order
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            drive(1'b0, 5'(i + 1), 10'(i));
            step();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        drive(1'b1, 5'd20, 10'd99);
        step();
        in_valid = 1'b0;
        chk("full_reject_count", 32'(count), 32'd4);
        chk("full_head", 32'(out_data), 32'(fill_word(0)));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_data", i), 32'(out_data), 32'(fill_word(i)));
            step();
            if (i == 0) chk("drain_in_ready", 32'(in_ready), 32'd1);
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);

        // streaming push+pop each cycle across several pointer wraps
        in_valid = 1'b1;
        drive(1'b1, 5'd3, 10'd0);
        step();
        out_ready = 1'b1;
        for (int k = 1; k < 20; k++) begin
            chk($sformatf("stream%0d_head", k), 32'(out_data), 32'(stream_word(k - 1)));
            drive(1'b1, 5'd3, 10'(k * 7));
            step();
            chk($sformatf("stream%0d_count", k), 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        chk("stream_last", 32'(out_data), 32'(stream_word(19)));
        step();
        out_ready = 1'b0;
        chk("stream_empty", 32'(count), 32'd0);

        // asynchronous reset with three entries buffered
        in_valid = 1'b1;
        drive(1'b0, 5'd31, 10'd5);
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_nan_cnt", 32'(nan_cnt), 32'd0);
        chk("async_out_data", 32'(out_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // NaN counter saturation
        in_valid = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 5'd31, 10'd1);
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 253) chk("nan_cnt_254", 32'(nan_cnt), 32'd254);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("nan_cnt_sat", 32'(nan_cnt), 32'hFF);
        chk("ftz_nan_cnt_sat", 32'(f_nan_cnt), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
